// File: rtl/satalnk_txcont_if.sv
// satalnk_txcont_if: upstream word stream and PHY-side output of the TX CONT encoder
interface satalnk_txcont_if;
   logic        s_valid;
   logic        s_ready;
   logic        s_primitive;
   logic [31:0] s_data;
   logic        o_primitive;
   logic [31:0] o_data;
   logic        o_align;
   modport master (output s_valid, s_primitive, s_data, input s_ready, o_primitive, o_data, o_align);
   modport slave (input s_valid, s_primitive, s_data, output s_ready, o_primitive, o_data, o_align);
endinterface

// File: rtl/satalnk_txcont.sv
// satalnk_txcont: SATA TX CONT compression and periodic ALIGN insertion.
// Define SATALNK_TXCONT_LFSR_EN to scramble junk words with an LFSR (zeros otherwise).
module satalnk_txcont #(
   parameter logic [31:0] P_ALIGN      = 32'h7B4A_4ABC,
   parameter logic [31:0] P_CONT       = 32'h9999_AA7C,
   parameter logic [31:0] P_SYNC       = 32'hB5B5_957C,
   parameter int          ALIGN_PERIOD = 256
) (
   input logic             i_clk,
   input logic             i_reset,
   input logic             i_cfg_continue_en,
   satalnk_txcont_if.slave lnk
);
   localparam int CW = $clog2(ALIGN_PERIOD);
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    run_q, run_d, run_n;
   logic [31:0]   last_q, last_d, data_q, data_d, item, junk;
   logic          last_data_q, last_data_d, prim_q, prim_d, align_q, align_d;
   logic          align_slot, take, item_prim, same, special;
`ifdef SATALNK_TXCONT_LFSR_EN
   logic [31:0]   lfsr_q, lfsr_d;
   assign junk = lfsr_q;
`else
   assign junk = '0;
`endif
   assign align_slot      = cnt_q >= CW'(ALIGN_PERIOD - 2);
   assign lnk.s_ready     = !i_reset && !align_slot;
   assign lnk.o_primitive = prim_q;
   assign lnk.o_data      = data_q;
   assign lnk.o_align     = align_q;
   always_comb begin
      take        = lnk.s_valid && lnk.s_ready;
      item_prim   = take ? lnk.s_primitive : 1'b1;
      item        = take ? lnk.s_data : (last_data_q ? P_SYNC : last_q);
      // an idle SYNC that follows data always starts a fresh run
      same        = (item == last_q) && (take || !last_data_q);
      special     = (item == P_ALIGN) || (item == P_CONT);
      run_n       = (!i_cfg_continue_en || !same) ? 2'd1 : (run_q == 2'd3 ? 2'd3 : run_q + 2'd1);
      cnt_d       = (cnt_q == CW'(ALIGN_PERIOD - 1)) ? '0 : cnt_q + 1'b1;
      run_d       = run_q;
      last_d      = last_q;
      last_data_d = last_data_q;
      prim_d      = 1'b1;
      data_d      = item;
      align_d     = 1'b0;
`ifdef SATALNK_TXCONT_LFSR_EN
      lfsr_d      = lfsr_q;
`endif
      if (align_slot) begin
         data_d  = P_ALIGN;
         align_d = 1'b1;
         run_d   = 2'd0;
      end else if (!item_prim) begin
         prim_d      = 1'b0;
         run_d       = 2'd0;
         last_data_d = 1'b1;
      end else if (special) begin
         run_d = 2'd0;
      end else begin
         run_d       = run_n;
         last_d      = item;
         last_data_d = 1'b0;
         if (run_n == 2'd3 && run_q == 2'd3) begin
            prim_d = 1'b0;
            data_d = junk;
`ifdef SATALNK_TXCONT_LFSR_EN
            lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
`endif
         end else if (run_n == 2'd3) begin
            data_d = P_CONT;
         end
      end
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt_q       <= '0;
         run_q       <= 2'd0;
         last_q      <= P_SYNC;
         last_data_q <= 1'b0;
         prim_q      <= 1'b1;
         data_q      <= P_SYNC;
         align_q     <= 1'b0;
`ifdef SATALNK_TXCONT_LFSR_EN
         lfsr_q      <= 32'hFFFF_FFFF;
`endif
      end else begin
         cnt_q       <= cnt_d;
         run_q       <= run_d;
         last_q      <= last_d;
         last_data_q <= last_data_d;
         prim_q      <= prim_d;
         data_q      <= data_d;
         align_q     <= align_d;
`ifdef SATALNK_TXCONT_LFSR_EN
         lfsr_q      <= lfsr_d;
`endif
      end
   end
endmodule

// File: tb/tb_satalnk_txcont.sv
// tb_satalnk_txcont: directed scoreboard bench for the TX CONT/ALIGN encoder
module tb_satalnk_txcont;
   localparam logic [31:0] ALIGN = 32'h7B4A_4ABC;
   localparam logic [31:0] CONT  = 32'h9999_AA7C;
   localparam logic [31:0] SYNC  = 32'hB5B5_957C;
   localparam logic [31:0] RRDY  = 32'h4A4A_957C;
   localparam logic [31:0] HOLD  = 32'hD5D5_AA7C;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg = 1'b0;
   logic [33:0] sb[$];
   int          vec = 0;
   int          bad = 0;
   int          cnt = 0;
   logic [31:0] lfsr_b = 32'hFFFF_FFFF;
   satalnk_txcont_if lnk();
   satalnk_txcont dut (.i_clk(clk), .i_reset(rst), .i_cfg_continue_en(cfg), .lnk(lnk));
   always #5 clk = ~clk;
   function automatic logic [31:0] junk();
`ifdef SATALNK_TXCONT_LFSR_EN
      junk   = lfsr_b;
      lfsr_b = {lfsr_b[30:0], lfsr_b[31] ^ lfsr_b[21] ^ lfsr_b[1] ^ lfsr_b[0]};
`else
      junk = 32'h0;
`endif
   endfunction
   task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      vec++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   // one cycle: drive, check ready mid-cycle, then check the registered output
   task automatic step(input string tag, input logic v, input logic p, input logic [31:0] d,
                       input logic ep, input logic [31:0] ed);
      logic sl;
      sl = cnt >= 254;
      lnk.s_valid = v;
      lnk.s_primitive = p;
      lnk.s_data = d;
      sb.push_back(sl ? {1'b1, 1'b1, ALIGN} : {1'b0, ep, ed});
      @(negedge clk);
      check({tag, "/ready"}, {33'b0, lnk.s_ready}, {33'b0, !sl});
      @(posedge clk);
      #1;
      check(tag, {lnk.o_align, lnk.o_primitive, lnk.o_data}, sb.pop_front());
      cnt = (cnt + 1) % 256;
   endtask
   initial begin
      lnk.s_valid = 1'b0;
      lnk.s_primitive = 1'b0;
      lnk.s_data = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_ready", {33'b0, lnk.s_ready}, 34'b0);
      check("reset_out", {lnk.o_align, lnk.o_primitive, lnk.o_data}, {2'b01, SYNC});
      rst = 1'b0;
      for (int k = 1; k <= 257; k++) step("idle_sync", 1'b0, 1'b0, 32'h0, 1'b1, SYNC);
      cfg = 1'b1;
      step("rrdy1", 1'b1, 1'b1, RRDY, 1'b1, RRDY);
      step("rrdy2", 1'b1, 1'b1, RRDY, 1'b1, RRDY);
      step("rrdy_cont", 1'b1, 1'b1, RRDY, 1'b1, CONT);
      for (int k = 0; k < 7; k++) step("rrdy_junk", 1'b1, 1'b1, RRDY, 1'b0, junk());
      step("hold1", 1'b1, 1'b1, HOLD, 1'b1, HOLD);
      step("hold2", 1'b1, 1'b1, HOLD, 1'b1, HOLD);
      step("hold_cont", 1'b1, 1'b1, HOLD, 1'b1, CONT);
      step("hold_junk", 1'b1, 1'b1, HOLD, 1'b0, junk());
      step("hold_junk", 1'b1, 1'b1, HOLD, 1'b0, junk());
      for (int k = 1; k <= 3; k++) step("data", 1'b1, 1'b0, 32'(k), 1'b0, 32'(k));
      step("rehold1", 1'b1, 1'b1, HOLD, 1'b1, HOLD);
      step("rehold2", 1'b1, 1'b1, HOLD, 1'b1, HOLD);
      step("rehold_cont", 1'b1, 1'b1, HOLD, 1'b1, CONT);
      step("rehold_junk", 1'b1, 1'b1, HOLD, 1'b0, junk());
      step("rehold_junk", 1'b1, 1'b1, HOLD, 1'b0, junk());
      cfg = 1'b0;
      step("cfg_off_raw", 1'b1, 1'b1, HOLD, 1'b1, HOLD);
      step("cfg_off_raw", 1'b1, 1'b1, HOLD, 1'b1, HOLD);
      while (cnt < 250) step("idle_repeat", 1'b0, 1'b0, 32'h0, 1'b1, HOLD);
      cfg = 1'b1;
      step("pre_align1", 1'b1, 1'b1, RRDY, 1'b1, RRDY);
      step("pre_align2", 1'b1, 1'b1, RRDY, 1'b1, RRDY);
      step("pre_align_cont", 1'b1, 1'b1, RRDY, 1'b1, CONT);
      step("pre_align_junk", 1'b1, 1'b1, RRDY, 1'b0, junk());
      step("align_a", 1'b1, 1'b1, RRDY, 1'b1, ALIGN);
      step("align_b", 1'b1, 1'b1, RRDY, 1'b1, ALIGN);
      step("post_align1", 1'b1, 1'b1, RRDY, 1'b1, RRDY);
      step("post_align2", 1'b1, 1'b1, RRDY, 1'b1, RRDY);
      step("post_align_cont", 1'b1, 1'b1, RRDY, 1'b1, CONT);
      step("post_align_junk", 1'b1, 1'b1, RRDY, 1'b0, junk());
      rst = 1'b1;
      sb.push_back({2'b01, SYNC});
      @(negedge clk);
      check("midrst_ready", {33'b0, lnk.s_ready}, 34'b0);
      @(posedge clk);
      #1;
      check("midrst_out", {lnk.o_align, lnk.o_primitive, lnk.o_data}, sb.pop_front());
      rst = 1'b0;
      cnt = 0;
      lfsr_b = 32'hFFFF_FFFF;
      step("rst_rrdy1", 1'b1, 1'b1, RRDY, 1'b1, RRDY);
      step("rst_rrdy2", 1'b1, 1'b1, RRDY, 1'b1, RRDY);
      step("rst_cont", 1'b1, 1'b1, RRDY, 1'b1, CONT);
      while (cnt < 254) step("rst_junk", 1'b1, 1'b1, RRDY, 1'b0, junk());
      step("rst_align_a", 1'b1, 1'b1, RRDY, 1'b1, ALIGN);
      step("rst_align_b", 1'b1, 1'b1, RRDY, 1'b1, ALIGN);
      step("rst_post_align", 1'b1, 1'b1, RRDY, 1'b1, RRDY);
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule
